// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the ram_fifo family.
// Default geometry, plus the fifo_state type used for debug and bench coverage.
package ram_fifo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Occupancy class derived purely from the count.
  function automatic fifo_state_t state_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0)     return EMPTY;
    if (cnt >= depth) return FULL;
    return PARTIAL;
  endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// Register-array RAM backing the FIFO.
// It has a synchronous write port and an asynchronous read port.
module ram_fifo_mem
  import ram_fifo_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset. The FIFO never exposes an entry before it is written, so the
  // array can stay plain flops with no reset network.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_fifo_4x4.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides, built on ram_fifo_mem.
// Optional macro RAM_FIFO_ALMOST_FLAGS_EN adds the almost_full and almost_empty outputs.
module ram_fifo_4x4
  import ram_fifo_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push;
  logic             pop;

  // Status flags decode the registered count only; no pop-to-push pass-through while full.
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count >= CNT_FULL - CNT_ONE);
  assign almost_empty = (count <= CNT_ONE);
`endif

  ram_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // NOTE: out_data gets its default first, so no path through this block can infer a latch.
  always_comb begin
    out_data = '0;
    if (!empty) out_data = rdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
